// File: rtl/uart_fifo_system_if.sv
// Host-side bus of the buffered UART: TX FIFO writes, RX FIFO reads,
// per-word error flags and the sticky overrun flag.
interface uart_fifo_system_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  tx_push;
   logic [DATA_WIDTH-1:0] tx_data;
   logic                  tx_full;
   logic                  tx_busy;
   logic                  rx_pop;
   logic [DATA_WIDTH-1:0] rx_data;
   logic                  rx_parity_err;
   logic                  rx_frame_err;
   logic                  rx_empty;
   logic                  rx_overrun;
   logic                  err_clear;

   modport master (
      output tx_push, tx_data, rx_pop, err_clear,
      input  tx_full, tx_busy, rx_data, rx_parity_err,
      input  rx_frame_err, rx_empty, rx_overrun
   );

   modport slave (
      input  tx_push, tx_data, rx_pop, err_clear,
      output tx_full, tx_busy, rx_data, rx_parity_err,
      output rx_frame_err, rx_empty, rx_overrun
   );
endinterface

// File: rtl/uart_fifo_system.sv
// Buffered UART: 16x baud generator, FIFO-fed transmitter and a receiver
// that stores {frame_err, parity_err, data} words in its own FIFO.
module uart_fifo_system_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = count == (AW+1)'(DEPTH);
   assign empty   = count == '0;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop) rptr <= rptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= wdata;
   end
endmodule

module uart_fifo_system #(
   parameter int DATA_WIDTH = 8,
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD_RATE  = 19200,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                clk,
   input  logic                rst,
   uart_fifo_system_if.slave   bus,
   output logic                tx,
   input  logic                rx
);
   localparam int DIV = CLK_FREQ / (BAUD_RATE * 16);
   localparam int CW  = $clog2(DIV + 1);
   localparam int BW  = $clog2(DATA_WIDTH + 1);
   localparam int EW  = DATA_WIDTH + 2;
   localparam logic ODD = PARITY == 1;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY_BIT, STOP} state_t;

   logic [CW-1:0] baud_cnt;
   logic          tick;

   assign tick = baud_cnt == CW'(DIV - 1);

   always_ff @(posedge clk) begin
      if (rst || tick) baud_cnt <= '0;
      else             baud_cnt <= baud_cnt + 1'b1;
   end

   state_t                tx_state, tx_state_n;
   logic [DATA_WIDTH-1:0] tx_shift, tx_shift_n, tx_head;
   logic [3:0]            tx_tcnt, tx_tcnt_n;
   logic [BW-1:0]         tx_bcnt, tx_bcnt_n;
   logic                  tx_par, tx_par_n;
   logic                  tx_pop, tx_empty, tx_end;

   uart_fifo_system_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) tx_fifo (
      .clk(clk), .rst(rst), .push(bus.tx_push), .pop(tx_pop),
      .wdata(bus.tx_data), .head(tx_head), .full(bus.tx_full), .empty(tx_empty)
   );

   assign tx_end      = tick && tx_tcnt == 4'd15;
   assign bus.tx_busy = tx_state != IDLE || !tx_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state <= IDLE;
         tx_shift <= '0;
         tx_tcnt  <= '0;
         tx_bcnt  <= '0;
         tx_par   <= 1'b0;
      end else begin
         tx_state <= tx_state_n;
         tx_shift <= tx_shift_n;
         tx_tcnt  <= tx_tcnt_n;
         tx_bcnt  <= tx_bcnt_n;
         tx_par   <= tx_par_n;
      end
   end

   always_comb begin
      tx_state_n = tx_state;
      tx_shift_n = tx_shift;
      tx_tcnt_n  = tx_tcnt;
      tx_bcnt_n  = tx_bcnt;
      tx_par_n   = tx_par;
      tx_pop     = 1'b0;
      tx         = 1'b1;
      if (tick && tx_state != IDLE) tx_tcnt_n = tx_tcnt + 1'b1;
      unique case (tx_state)
         IDLE: tx_pop = tick && !tx_empty;
         START: begin
            tx = 1'b0;
            if (tx_end) begin
               tx_state_n = DATA;
               tx_bcnt_n  = '0;
            end
         end
         DATA: begin
            tx = tx_shift[0];
            if (tx_end) begin
               tx_shift_n = tx_shift >> 1;
               tx_bcnt_n  = tx_bcnt + 1'b1;
               if (tx_bcnt == BW'(DATA_WIDTH - 1)) begin
                  tx_state_n = (PARITY != 0) ? PARITY_BIT : STOP;
                  tx_bcnt_n  = '0;
               end
            end
         end
         PARITY_BIT: begin
            tx = tx_par;
            if (tx_end) begin
               tx_state_n = STOP;
               tx_bcnt_n  = '0;
            end
         end
         STOP: begin
            if (tx_end) begin
               tx_bcnt_n = tx_bcnt + 1'b1;
               if (tx_bcnt == BW'(STOP_BITS - 1)) begin
                  tx_state_n = IDLE;
                  tx_pop     = !tx_empty;
               end
            end
         end
         default: tx_state_n = IDLE;
      endcase
      // back-to-back frames load straight from the end of STOP
      if (tx_pop) begin
         tx_state_n = START;
         tx_shift_n = tx_head;
         tx_par_n   = ^tx_head ^ ODD;
         tx_tcnt_n  = '0;
      end
   end

   logic [1:0]            rx_sync;
   logic                  rxs;
   state_t                rx_state, rx_state_n;
   logic [DATA_WIDTH-1:0] rx_shift, rx_shift_n;
   logic [3:0]            rx_tcnt, rx_tcnt_n;
   logic [BW-1:0]         rx_bcnt, rx_bcnt_n;
   logic                  rx_perr, rx_perr_n;
   logic                  rx_push, rx_full, rx_empty, rx_end;
   logic [EW-1:0]         rx_entry, rx_head;
   logic                  overrun;

   assign rxs    = rx_sync[1];
   assign rx_end = tick && rx_tcnt == 4'd15;

   uart_fifo_system_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) rx_fifo (
      .clk(clk), .rst(rst), .push(rx_push), .pop(bus.rx_pop),
      .wdata(rx_entry), .head(rx_head), .full(rx_full), .empty(rx_empty)
   );

   assign bus.rx_empty      = rx_empty;
   assign bus.rx_data       = rx_empty ? '0 : rx_head[DATA_WIDTH-1:0];
   assign bus.rx_parity_err = !rx_empty && rx_head[DATA_WIDTH];
   assign bus.rx_frame_err  = !rx_empty && rx_head[DATA_WIDTH+1];
   assign bus.rx_overrun    = overrun;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_sync  <= 2'b11;
         rx_state <= IDLE;
         rx_shift <= '0;
         rx_tcnt  <= '0;
         rx_bcnt  <= '0;
         rx_perr  <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         rx_sync  <= {rx_sync[0], rx};
         rx_state <= rx_state_n;
         rx_shift <= rx_shift_n;
         rx_tcnt  <= rx_tcnt_n;
         rx_bcnt  <= rx_bcnt_n;
         rx_perr  <= rx_perr_n;
         if (rx_push && rx_full) overrun <= 1'b1;
         else if (bus.err_clear) overrun <= 1'b0;
      end
   end

   always_comb begin
      rx_state_n = rx_state;
      rx_shift_n = rx_shift;
      rx_tcnt_n  = rx_tcnt;
      rx_bcnt_n  = rx_bcnt;
      rx_perr_n  = rx_perr;
      rx_push    = 1'b0;
      rx_entry   = {~rxs, rx_perr, rx_shift};
      if (tick && rx_state != IDLE) rx_tcnt_n = rx_tcnt + 1'b1;
      unique case (rx_state)
         IDLE: begin
            if (tick && !rxs) begin
               rx_state_n = START;
               rx_tcnt_n  = '0;
            end
         end
         START: begin
            // mid start bit: a high line here was only a glitch
            if (tick && rx_tcnt == 4'd7) begin
               rx_state_n = rxs ? IDLE : DATA;
               rx_tcnt_n  = '0;
               rx_bcnt_n  = '0;
               rx_perr_n  = 1'b0;
            end
         end
         DATA: begin
            if (rx_end) begin
               rx_shift_n = {rxs, rx_shift[DATA_WIDTH-1:1]};
               rx_bcnt_n  = rx_bcnt + 1'b1;
               if (rx_bcnt == BW'(DATA_WIDTH - 1))
                  rx_state_n = (PARITY != 0) ? PARITY_BIT : STOP;
            end
         end
         PARITY_BIT: begin
            if (rx_end) begin
               rx_perr_n  = rxs ^ (^rx_shift) ^ ODD;
               rx_state_n = STOP;
            end
         end
         STOP: begin
            if (rx_end) begin
               rx_push    = 1'b1;
               rx_state_n = IDLE;
            end
         end
         default: rx_state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_uart_fifo_system.sv
// Directed bench: 8N1 instance with optional loopback and an 8E1 instance
// driven from a bit-level line model.
module tb_uart_fifo_system;
   localparam int CF  = 3_072_000;
   localparam int BR  = 19200;
   localparam int BIT = 160;

   typedef struct {
      logic [7:0] data;
      logic       par;
      logic       stop;
      logic       perr;
      logic       ferr;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tx0, tx1, rx0, rx1, drv0, loop0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   uart_fifo_system_if #(.DATA_WIDTH(8)) b0 ();
   uart_fifo_system_if #(.DATA_WIDTH(8)) b1 ();

   assign rx0 = loop0 ? tx0 : drv0;

   uart_fifo_system #(
      .DATA_WIDTH(8), .CLK_FREQ(CF), .BAUD_RATE(BR),
      .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)
   ) dut0 (.clk(clk), .rst(rst), .bus(b0), .tx(tx0), .rx(rx0));

   uart_fifo_system #(
      .DATA_WIDTH(8), .CLK_FREQ(CF), .BAUD_RATE(BR),
      .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)
   ) dut1 (.clk(clk), .rst(rst), .bus(b1), .tx(tx1), .rx(rx1));

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input int d, input logic [7:0] w);
      if (d == 0) begin b0.tx_push = 1'b1; b0.tx_data = w; end
      else        begin b1.tx_push = 1'b1; b1.tx_data = w; end
      @(negedge clk);
      b0.tx_push = 1'b0;
      b1.tx_push = 1'b0;
   endtask

   task automatic pop(input int d);
      if (d == 0) b0.rx_pop = 1'b1;
      else        b1.rx_pop = 1'b1;
      @(negedge clk);
      b0.rx_pop = 1'b0;
      b1.rx_pop = 1'b0;
   endtask

   task automatic wait_rx(input int d, input int lim, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < lim; i++) begin
         @(negedge clk);
         if ((d == 0 ? b0.rx_empty : b1.rx_empty) == 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_low(input int d, input int lim, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < lim; i++) begin
         @(negedge clk);
         if ((d == 0 ? tx0 : tx1) == 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic send(input int d, input logic [10:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         if (d == 0) drv0 = bits[i];
         else        rx1  = bits[i];
         cyc(BIT);
      end
      drv0 = 1'b1;
      rx1  = 1'b1;
   endtask

   initial begin
      vec_t       lb [4];
      vec_t       pv [6];
      bit         ok;
      logic [9:0] eb;
      int         lows;

      lb[0] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
      lb[1] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
      lb[2] = '{8'h3C, 1'b0, 1'b1, 1'b0, 1'b0};
      lb[3] = '{8'h81, 1'b0, 1'b1, 1'b0, 1'b0};
      pv[0] = '{8'h07, 1'b0, 1'b1, 1'b1, 1'b0};
      pv[1] = '{8'h07, 1'b1, 1'b1, 1'b0, 1'b0};
      pv[2] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
      pv[3] = '{8'h81, 1'b1, 1'b1, 1'b1, 1'b0};
      pv[4] = '{8'hFE, 1'b1, 1'b1, 1'b0, 1'b0};
      pv[5] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b1};

      b0.tx_push = 0; b0.tx_data = 0; b0.rx_pop = 0; b0.err_clear = 0;
      b1.tx_push = 0; b1.tx_data = 0; b1.rx_pop = 0; b1.err_clear = 0;
      drv0 = 1'b1; rx1 = 1'b1; loop0 = 1'b1;

      cyc(3);
      chk("rst_tx", tx0, 1);
      chk("rst_tx_full", b0.tx_full, 0);
      chk("rst_tx_busy", b0.tx_busy, 0);
      chk("rst_rx_empty", b0.rx_empty, 1);
      chk("rst_rx_data", b0.rx_data, 0);
      chk("rst_perr", b0.rx_parity_err, 0);
      chk("rst_ferr", b0.rx_frame_err, 0);
      chk("rst_overrun", b0.rx_overrun, 0);
      chk("rst_tx1", tx1, 1);
      rst = 1'b0;
      cyc(2);

      // 8N1 loopback with bit-level line check
      push(0, 8'hA5);
      wait_low(0, 12, ok);
      chk("tx_latency", ok, 1);
      eb = {1'b1, 8'hA5, 1'b0};
      cyc(80);
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("a5_bit%0d", i), tx0, eb[i]);
         if (i < 9) cyc(BIT);
      end
      wait_rx(0, 400, ok);
      chk("a5_rx_wait", ok, 1);
      chk("a5_data", b0.rx_data, 8'hA5);
      chk("a5_perr", b0.rx_parity_err, 0);
      chk("a5_ferr", b0.rx_frame_err, 0);
      pop(0);

      foreach (lb[k]) begin
         push(0, lb[k].data);
         wait_rx(0, 2000, ok);
         chk($sformatf("lb%0d_wait", k), ok, 1);
         chk($sformatf("lb%0d_data", k), b0.rx_data, lb[k].data);
         chk($sformatf("lb%0d_perr", k), b0.rx_parity_err, lb[k].perr);
         chk($sformatf("lb%0d_ferr", k), b0.rx_frame_err, lb[k].ferr);
         pop(0);
         chk($sformatf("lb%0d_empty", k), b0.rx_empty, 1);
      end
      cyc(2 * BIT);

      // 8E1 transmit parity bit for 0x07 is 1
      push(1, 8'h07);
      wait_low(1, 12, ok);
      chk("p_tx_start", ok, 1);
      cyc(80 + 9 * BIT);
      chk("p_tx_parity", tx1, 1);
      cyc(2 * BIT);

      foreach (pv[k]) begin
         cyc(BIT);
         send(1, {pv[k].stop, pv[k].par, pv[k].data, 1'b0}, 11);
         wait_rx(1, 200, ok);
         chk($sformatf("pv%0d_wait", k), ok, 1);
         chk($sformatf("pv%0d_data", k), b1.rx_data, pv[k].data);
         chk($sformatf("pv%0d_perr", k), b1.rx_parity_err, pv[k].perr);
         chk($sformatf("pv%0d_ferr", k), b1.rx_frame_err, pv[k].ferr);
         pop(1);
         cyc(2 * BIT);
         chk($sformatf("pv%0d_empty", k), b1.rx_empty, 1);
      end

      // break: line low for 10 bit periods
      loop0 = 1'b0;
      drv0  = 1'b0;
      cyc(10 * BIT);
      drv0 = 1'b1;
      wait_rx(0, 400, ok);
      chk("brk_wait", ok, 1);
      chk("brk_data", b0.rx_data, 0);
      chk("brk_ferr", b0.rx_frame_err, 1);
      chk("brk_perr", b0.rx_parity_err, 0);
      pop(0);
      cyc(3 * BIT);
      chk("brk_single", b0.rx_empty, 1);

      // glitch of 4 ticks, then a clean frame
      drv0 = 1'b0;
      cyc(40);
      drv0 = 1'b1;
      cyc(3 * BIT);
      chk("glitch_empty", b0.rx_empty, 1);
      send(0, {1'b0, 1'b1, 8'h3C, 1'b0}, 10);
      wait_rx(0, 200, ok);
      chk("glitch_after_wait", ok, 1);
      chk("glitch_after_data", b0.rx_data, 8'h3C);
      pop(0);
      cyc(2 * BIT);

      // FIFO bounds through loopback
      loop0 = 1'b1;
      for (int i = 0; i < 18; i++) begin
         b0.tx_push = 1'b1;
         b0.tx_data = 8'(8'h40 + i);
         @(negedge clk);
      end
      b0.tx_push = 1'b0;
      chk("bnd_tx_full", b0.tx_full, 1);
      chk("bnd_tx_busy", b0.tx_busy, 1);
      ok = 1'b0;
      for (int i = 0; i < 30000; i++) begin
         @(negedge clk);
         if (!b0.tx_busy) begin ok = 1'b1; break; end
      end
      chk("bnd_tx_drain", ok, 1);
      cyc(BIT);
      chk("bnd_overrun", b0.rx_overrun, 1);
      b0.err_clear = 1'b1;
      @(negedge clk);
      b0.err_clear = 1'b0;
      chk("bnd_overrun_clr", b0.rx_overrun, 0);
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("bnd_word%0d", i), b0.rx_data, 8'(8'h40 + i));
         pop(0);
      end
      chk("bnd_rx_empty", b0.rx_empty, 1);

      // reset during TX data bit 3
      push(0, 8'h99);
      wait_low(0, 12, ok);
      chk("rmf_start", ok, 1);
      cyc(80 + 4 * BIT);
      rst = 1'b1;
      @(negedge clk);
      chk("rmf_tx", tx0, 1);
      chk("rmf_tx_busy", b0.tx_busy, 0);
      chk("rmf_rx_empty", b0.rx_empty, 1);
      rst  = 1'b0;
      lows = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (tx0 == 1'b0) lows++;
      end
      chk("rmf_line_quiet", lows, 0);
      chk("rmf_rx_quiet", b0.rx_empty, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_fifo_system.md
# uart_fifo_system

Buffered, parametrised UART for processor-to-host links. It contains a 16x-oversampling baud generator, a transmitter and a receiver, each behind its own FIFO. Data width, parity mode, stop-bit count and FIFO depth are compile-time parameters. Received words carry per-word parity and framing error flags, and the receiver keeps a sticky overrun flag, so cores can burst words without waiting on the line.

## Interface
- DATA_WIDTH, 8: payload bits per frame, legal 5..9.
- CLK_FREQ, 50_000_000: clk frequency in Hz.
- BAUD_RATE, 19200: line rate.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2, transmitted.
- FIFO_DEPTH, 16: entries per FIFO, power of two, at least 2.
- clk  in  1  sole clock.
- rst  in  1  synchronous reset, active-high.
- tx_push  in  1  write tx_data into the TX FIFO.
- tx_data  in  DATA_WIDTH  word to send.
- tx_full  out  1  TX FIFO full.
- tx_busy  out  1  a frame is on the line or the TX FIFO is non-empty.
- tx  out  1  serial output, idle high.
- rx  in  1  serial input, asynchronous.
- rx_pop  in  1  drop the RX FIFO head.
- rx_data  out  DATA_WIDTH  RX FIFO head (first-word fall-through).
- rx_parity_err  out  1  parity error flag of the head word.
- rx_frame_err  out  1  framing error flag of the head word.
- rx_empty  out  1  RX FIFO empty.
- rx_overrun  out  1  sticky: a received word was dropped.
- err_clear  in  1  clears rx_overrun.

## Operation
- **Baud generator**
  - DIV = CLK_FREQ / (BAUD_RATE*16), integer floor.
  - The counter runs 0..DIV-1 and pulses tick for one cycle at DIV-1.
  - One bit period = 16 ticks = 16*DIV clocks.
- **FIFOs**
  - Circular buffers with count width log2(FIFO_DEPTH)+1.
  - A push while full is ignored, even if a pop occurs in the same cycle.
  - A pop while empty is ignored.
  - A simultaneous push and pop on a non-empty FIFO leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - The RX FIFO entry is {frame_err, parity_err, data}.
- **Transmitter FSM: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE**
  - PARITY is skipped when PARITY = 0.
  - IDLE: tx = 1. On a tick with the TX FIFO non-empty, pop the FIFO into the shift register and go to START.
  - Each state lasts 16 ticks per bit.
  - DATA shifts LSB first for DATA_WIDTH bits.
  - Parity bit: even = XOR of the data bits; odd = its inverse.
  - STOP drives 1 for STOP_BITS bit periods.
  - The next frame may start on the tick that ends STOP; there is no extra idle bit.
- **Receiver**
  - rx passes through a 2-flop synchroniser, reset value 1.
  - FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: synchronised rx = 0 on a tick moves to START and clears the tick counter.
  - START: at tick 7, if rx = 1 the event is a glitch and the FSM returns to IDLE; otherwise go to DATA.
  - Sampling then occurs every 16 ticks, at mid-bit.
  - Data is assembled LSB first.
  - parity_err = received parity bit differs from the computed parity; it is 0 when PARITY = 0.
  - Only the first stop bit is checked; frame_err = (sample == 0).
  - At the stop sample, push the entry into the RX FIFO and return to IDLE.
  - If the RX FIFO is full, discard the word and set rx_overrun.
  - A break (all zeros, frame_err = 1) is pushed like any other word.
  - The receiver does not wait for rx to return high. IDLE re-arms on rx low, so a held-low line yields repeated frame_err words.
- **rx_overrun**
  - Set by a drop, cleared by err_clear.
  - When a drop and err_clear occur in the same cycle, set wins.

## Timing
- **Reset values:** tx = 1, tx_full = 0, tx_busy = 0, rx_empty = 1, rx_data = 0, rx_parity_err = 0, rx_frame_err = 0, rx_overrun = 0. Both FIFOs are empty, both FSMs are in IDLE, and the baud counter is 0.
- **Reset mid-frame:** tx is 1 on the cycle after rst is sampled. Partial frames are discarded.
- **Flag latency:** tx_full, rx_empty and the count-derived flags update on the cycle after the push/pop edge.
- **rx_data / error flags:** combinational from the head entry.
- **TX latency:** push into an idle, empty TX FIFO -> tx falls within DIV+2 cycles.
- **RX latency:** the word appears at the RX FIFO head 1 cycle after the mid-stop-bit sample, i.e. about (1.5 + DATA_WIDTH + parity bit) bit periods after the falling edge, plus 2 synchroniser cycles.

## Test plan
Common setup: CLK_FREQ = 3_072_000, BAUD_RATE = 19200, so DIV = 10 and 160 clocks per bit. Loopback is tx -> rx.

- **8N1 loopback:** push 0xA5. Required: tx shows bits 0,1,0,1,0,0,1,0,1,1 at 160 clocks each, then rx_empty = 0, rx_data = 0xA5 and both error flags 0.
- **Parity (PARITY = 2, 8E1):** push 0x07; tx parity bit = 1. Drive an external frame 0x07 with parity 0. Required: rx_data = 0x07, rx_parity_err = 1.
- **Framing/break:** drive rx low for 10 bit periods, then high. Required: a word 0x00 with rx_frame_err = 1.
- **FIFO bounds (FIFO_DEPTH = 16):**
  - Push 18 words back-to-back from idle: word 0 is popped to the line, words 1..16 fill the FIFO, tx_full = 1 and word 17 is lost. The line then carries words 0..16 in order.
  - RX: receive 17 frames without popping: 16 are stored and rx_overrun = 1. Pulsing err_clear returns it to 0; popping yields the first 16 words in order.
- **Glitch rejection:** rx low for 40 clocks (4 ticks) then high. Required: no word is pushed and the receiver returns to IDLE.
- **Reset mid-frame:** assert rst during TX data bit 3. Required: tx = 1, tx_busy = 0 and rx_empty = 1 on the next cycle, and no output on the line afterwards.
